// File: rtl/elevator_motion_controller_if.sv
// elevator_motion_controller_if
//   Bundles the car-side signals between the call panel, the closest-floor
//   calculator and the motion controller.
//   master : environment side (drives buttons, target; optional estop)
//   slave  : controller side (drives requests, location, status flags)
//   Optional macro ESTOP_EN adds the estop signal.
//   Signals:
//     buttons     [0:9] floor-call pulses, bit 0 = floor 1
//     target      [3:0] closest requested floor from the calculator, 1..10
//     requests    [0:9] latched pending calls
//     location    [3:0] current car floor, 1..10
//     moving_up, moving_down, door_open : status flags
interface elevator_motion_controller_if;
  logic [0:9] buttons;
  logic [3:0] target;
  logic [0:9] requests;
  logic [3:0] location;
  logic       moving_up;
  logic       moving_down;
  logic       door_open;
`ifdef ESTOP_EN
  logic       estop;

  modport master (
    output buttons, target, estop,
    input  requests, location, moving_up, moving_down, door_open
  );

  modport slave (
    input  buttons, target, estop,
    output requests, location, moving_up, moving_down, door_open
  );
`else
  modport master (
    output buttons, target,
    input  requests, location, moving_up, moving_down, door_open
  );

  modport slave (
    input  buttons, target,
    output requests, location, moving_up, moving_down, door_open
  );
`endif
endinterface

// File: rtl/elevator_motion_controller.sv
// elevator_motion_controller
//   Car sequencer for a 10-floor elevator. Latches floor calls, feeds the
//   request vector and location to the closest-floor calculator, follows the
//   calculator's registered target one floor per FLOOR_TICKS cycles and holds
//   the door open for DOOR_TICKS cycles on arrival.
//   Optional macro ESTOP_EN: adds bus.estop, which freezes timer, state and
//   location and forces the status flags low while high.
//   Ports:
//     clk  system clock
//     rst  synchronous active-high reset
//     bus  elevator_motion_controller_if.slave (buttons/target in,
//          requests/location/moving_up/moving_down/door_open out)
//
//   state     | meaning
//   ----------+------------------------------------------------
//   IDLE      | no valid target, car parked at location
//   MOVE_UP   | travelling up, timer counts down to next floor
//   MOVE_DOWN | travelling down, timer counts down to next floor
//   DOOR_OPEN | door open at location, timer counts down
module elevator_motion_controller #(
  parameter int FLOOR_TICKS = 50,
  parameter int DOOR_TICKS  = 100,
  parameter int RESET_FLOOR = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  elevator_motion_controller_if.slave   bus
);

  localparam int MAX_TICKS = (FLOOR_TICKS > DOOR_TICKS) ? FLOOR_TICKS : DOOR_TICKS;
  localparam int TW        = $clog2(MAX_TICKS);
  localparam logic [TW-1:0] FLOOR_LOAD = TW'(FLOOR_TICKS - 1);
  localparam logic [TW-1:0] DOOR_LOAD  = TW'(DOOR_TICKS - 1);

  typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN} state_t;

  state_t      state, state_d;
  logic [TW-1:0] timer, timer_d;
  logic [3:0]  loc_d;
  logic [0:9]  req_d;
  logic [0:9]  set_mask;
  logic        up_d, down_d, door_d;
  logic        freeze;
  logic        do_eval;
  logic [3:0]  eval_loc;
  logic [0:9]  here_mask;
  logic        tgt_valid;

  // One-hot floor select; out-of-range floors give an all-zero mask, which
  // makes an out-of-range target naturally invalid.
  function automatic logic [0:9] floor_mask(input logic [3:0] f);
    logic [0:9] m;
    for (int i = 0; i < 10; i++) m[i] = (f == 4'(i + 1));
    return m;
  endfunction

`ifdef ESTOP_EN
  assign freeze = bus.estop;
`else
  assign freeze = 1'b0;
`endif

  assign here_mask = floor_mask(bus.location);
  assign tgt_valid = |(floor_mask(bus.target) & bus.requests);

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      timer           <= '0;
      bus.location    <= 4'(RESET_FLOOR);
      bus.requests    <= '0;
      bus.moving_up   <= 1'b0;
      bus.moving_down <= 1'b0;
      bus.door_open   <= 1'b0;
    end else begin
      state           <= state_d;
      timer           <= timer_d;
      bus.location    <= loc_d;
      bus.requests    <= req_d;
      bus.moving_up   <= up_d;
      bus.moving_down <= down_d;
      bus.door_open   <= door_d;
    end
  end

  always_comb begin
    state_d  = state;
    timer_d  = timer;
    loc_d    = bus.location;
    do_eval  = 1'b0;
    eval_loc = bus.location;
    if (!freeze) begin
      case (state)
        IDLE: do_eval = 1'b1;
        MOVE_UP: begin
          if (timer != '0) timer_d = timer - TW'(1);
          else if (bus.location == 4'd10) state_d = IDLE;
          else begin
            loc_d    = bus.location + 4'd1;
            eval_loc = loc_d;
            do_eval  = 1'b1;
          end
        end
        MOVE_DOWN: begin
          if (timer != '0) timer_d = timer - TW'(1);
          else if (bus.location <= 4'd1) state_d = IDLE;
          else begin
            loc_d    = bus.location - 4'd1;
            eval_loc = loc_d;
            do_eval  = 1'b1;
          end
        end
        DOOR_OPEN: begin
          // A call for this floor keeps the door open instead of latching.
          if (|(bus.buttons & here_mask)) timer_d = DOOR_LOAD;
          else if (timer == '0) state_d = IDLE;
          else timer_d = timer - TW'(1);
        end
        default: state_d = IDLE;
      endcase
    end

    // Floor-boundary decision uses the freshly stepped location.
    if (do_eval) begin
      if (!tgt_valid) state_d = IDLE;
      else if (bus.target == eval_loc) begin
        state_d = DOOR_OPEN;
        timer_d = DOOR_LOAD;
      end else if (bus.target > eval_loc) begin
        state_d = MOVE_UP;
        timer_d = FLOOR_LOAD;
      end else begin
        state_d = MOVE_DOWN;
        timer_d = FLOOR_LOAD;
      end
    end

    set_mask = bus.buttons;
    if (state == DOOR_OPEN) set_mask = set_mask & ~here_mask;
    req_d = bus.requests | set_mask;
    // Clear on door entry overrides a same-cycle press.
    if (state_d == DOOR_OPEN && state != DOOR_OPEN)
      req_d = req_d & ~floor_mask(loc_d);
  end

  always_comb begin
    up_d   = (state_d == MOVE_UP)   && !freeze;
    down_d = (state_d == MOVE_DOWN) && !freeze;
    door_d = (state_d == DOOR_OPEN) && !freeze;
  end

endmodule

// File: tb/tb_elevator_motion_controller.sv
// Directed bench for elevator_motion_controller with a registered
// closest-floor calculator model closing the loop (ties go to the lower floor,
// 10 when no request is pending). FLOOR_TICKS=4, DOOR_TICKS=5, RESET_FLOOR=1.
module tb_elevator_motion_controller;
  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  elevator_motion_controller_if bus();

  elevator_motion_controller #(
    .FLOOR_TICKS(4),
    .DOOR_TICKS (5),
    .RESET_FLOOR(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  function automatic logic [3:0] calc(input logic [0:9] r, input logic [3:0] loc);
    int best = 10;
    int bd   = 99;
    int d;
    for (int i = 0; i < 10; i++) begin
      if (r[i]) begin
        d = (i + 1 > int'(loc)) ? (i + 1 - int'(loc)) : (int'(loc) - i - 1);
        if (d < bd) begin
          bd   = d;
          best = i + 1;
        end
      end
    end
    return 4'(best);
  endfunction

  always @(posedge clk) begin
    if (rst) bus.target <= 4'd10;
    else     bus.target <= calc(bus.requests, bus.location);
  end

  function automatic logic [0:9] fb(input int f);
    logic [0:9] m;
    m = '0;
    m[f-1] = 1'b1;
    return m;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [0:9] m);
    bus.buttons = m;
    step();
    bus.buttons = '0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_door(input logic level, input int budget, input string tag);
    int n = 0;
    while (bus.door_open !== level && n < budget) begin
      step();
      n++;
    end
    check(tag, 32'(bus.door_open), 32'(level));
  endtask

  initial begin
    rst = 1'b1;
    bus.buttons = '0;
`ifdef ESTOP_EN
    bus.estop = 1'b0;
`endif
    step();
    step();
    check("rst_location", 32'(bus.location), 32'd1);
    check("rst_requests", 32'(bus.requests), 32'd0);
    check("rst_up",       32'(bus.moving_up), 32'd0);
    check("rst_down",     32'(bus.moving_down), 32'd0);
    check("rst_door",     32'(bus.door_open), 32'd0);
    rst = 1'b0;

    // Upward trip 1 -> 4
    press(fb(4));
    check("up_latch",   32'(bus.requests[3]), 32'd1);
    check("up_wait1",   32'(bus.moving_up), 32'd0);
    step();
    check("up_wait2",   32'(bus.moving_up), 32'd0);
    step();
    check("up_start",   32'(bus.moving_up), 32'd1);
    repeat (3) step();
    check("up_hold1",   32'(bus.location), 32'd1);
    step();
    check("up_floor2",  32'(bus.location), 32'd2);
    repeat (4) step();
    check("up_floor3",  32'(bus.location), 32'd3);
    check("up_moving3", 32'(bus.moving_up), 32'd1);
    repeat (4) step();
    check("up_floor4",  32'(bus.location), 32'd4);
    check("up_door4",   32'(bus.door_open), 32'd1);
    check("up_stop4",   32'(bus.moving_up), 32'd0);
    check("up_clear4",  32'(bus.requests[3]), 32'd0);
    repeat (4) step();
    check("door4_last", 32'(bus.door_open), 32'd1);
    step();
    check("door4_shut", 32'(bus.door_open), 32'd0);

    // One floor up to 5
    press(fb(5));
    step();
    step();
    check("to5_start",  32'(bus.moving_up), 32'd1);
    repeat (4) step();
    check("to5_loc",    32'(bus.location), 32'd5);
    check("to5_door",   32'(bus.door_open), 32'd1);
    repeat (5) step();
    check("to5_shut",   32'(bus.door_open), 32'd0);

    // Current-floor call at 5
    press(fb(5));
    check("cur_latch",  32'(bus.requests[4]), 32'd1);
    check("cur_wait1",  32'(bus.door_open), 32'd0);
    step();
    check("cur_wait2",  32'(bus.door_open), 32'd0);
    step();
    check("cur_door",   32'(bus.door_open), 32'd1);
    check("cur_clear",  32'(bus.requests[4]), 32'd0);
    repeat (4) step();
    check("cur_last",   32'(bus.door_open), 32'd1);
    step();
    check("cur_shut",   32'(bus.door_open), 32'd0);

    // Empty requests: stays idle
    repeat (3) step();
    check("idle_up",    32'(bus.moving_up), 32'd0);
    check("idle_down",  32'(bus.moving_down), 32'd0);
    check("idle_door",  32'(bus.door_open), 32'd0);
    check("idle_loc",   32'(bus.location), 32'd5);

    // Re-press mid-door extends by a full DOOR_TICKS
    press(fb(5));
    step();
    step();
    check("ext_door",   32'(bus.door_open), 32'd1);
    step();
    step();
    press(fb(5));
    check("ext_nolatch", 32'(bus.requests[4]), 32'd0);
    check("ext_open",    32'(bus.door_open), 32'd1);
    repeat (4) step();
    check("ext_last",    32'(bus.door_open), 32'd1);
    step();
    check("ext_shut",    32'(bus.door_open), 32'd0);

    // Reset during MOVE_DOWN
    press(fb(1));
    step();
    step();
    check("dn_start",   32'(bus.moving_down), 32'd1);
    step();
    check("dn_loc5",    32'(bus.location), 32'd5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("dnrst_loc",  32'(bus.location), 32'd1);
    check("dnrst_req",  32'(bus.requests), 32'd0);
    check("dnrst_down", 32'(bus.moving_down), 32'd0);

    // Redirect: heading for 9, call at 3 while between 1 and 2
    press(fb(9));
    step();
    step();
    check("rd_start",   32'(bus.moving_up), 32'd1);
    step();
    press(fb(3));
    check("rd_latch3",  32'(bus.requests[2]), 32'd1);
    check("rd_loc1",    32'(bus.location), 32'd1);
    step();
    step();
    check("rd_loc2",    32'(bus.location), 32'd2);
    check("rd_up2",     32'(bus.moving_up), 32'd1);
    repeat (4) step();
    check("rd_loc3",    32'(bus.location), 32'd3);
    check("rd_door3",   32'(bus.door_open), 32'd1);
    check("rd_clear3",  32'(bus.requests[2]), 32'd0);
    check("rd_keep9",   32'(bus.requests[8]), 32'd1);
    wait_door(1'b0, 20, "rd_door3_shut");
    wait_door(1'b1, 60, "rd_door9_open");
    check("rd_loc9",    32'(bus.location), 32'd9);
    check("rd_clear9",  32'(bus.requests[8]), 32'd0);
    wait_door(1'b0, 20, "rd_door9_shut");

`ifdef ESTOP_EN
    // Estop mid-travel 9 -> 8
    press(fb(8));
    step();
    step();
    check("es_start",   32'(bus.moving_down), 32'd1);
    step();
    bus.estop = 1'b1;
    repeat (10) step();
    check("es_down0",   32'(bus.moving_down), 32'd0);
    check("es_loc",     32'(bus.location), 32'd9);
    bus.estop = 1'b0;
    step();
    step();
    check("es_resume",  32'(bus.moving_down), 32'd1);
    check("es_loc_hold", 32'(bus.location), 32'd9);
    step();
    check("es_loc8",    32'(bus.location), 32'd8);
    check("es_door8",   32'(bus.door_open), 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
